// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD decode path: digit widths, the decoder
// state type and the nibble validity test.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int DEC_W   = 10;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic bcd_valid(input logic [DIGIT_W-1:0] nibble);
    return nibble <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_decoder.sv
// Single BCD digit to 10-bit one-hot decimal code; counterpart of the
// decimal-to-BCD encoder, usable directly by display drivers.
module bcd_digit_decoder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [DEC_W-1:0]   dec,
  output logic               invalid
);

  // NOTE: every output of a combinational block gets a default first, so
  // no path through the block can leave one unassigned and infer a latch.
  always_comb begin
    dec     = '0;
    invalid = !bcd_valid(nibble);
    if (!invalid) dec = DEC_W'(1) << nibble;
  end

endmodule

// File: rtl/bcd_to_decimal_decoder_seq.sv
// Streams a packed BCD word out one one-hot digit per handshake, most
// significant first, with optional leading-zero suppression.
module bcd_to_decimal_decoder_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SUPPRESS_LZ = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DEC_W-1:0]        out_dec,
  output logic                    out_last,
  output logic                    out_err,
  output logic                    err_flag,
  output logic                    busy
);

  localparam int WORD_W = DIGIT_W * DIGITS;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lz_q, lz_d;
  logic                err_flag_q, err_flag_d;

  logic [DIGIT_W-1:0]  nibble;
  logic [DEC_W-1:0]    dec_raw;
  logic                nibble_bad;
  logic                emitting;
  logic                skipping;
  logic                accept;

  assign nibble = shreg_q[WORD_W-1 -: DIGIT_W];

  bcd_digit_decoder u_digit (
    .nibble  (nibble),
    .dec     (dec_raw),
    .invalid (nibble_bad)
  );

  assign emitting  = (state_q == EMIT);
  assign skipping  = emitting && lz_q && (nibble == '0) && (cnt_q != '0);

  assign out_valid = emitting && !skipping;
  assign out_dec   = emitting ? dec_raw : '0;
  assign out_err   = emitting && nibble_bad;
  assign out_last  = emitting && (cnt_q == '0);
  assign busy      = emitting;
  assign err_flag  = err_flag_q;

  // The last-digit handshake frees the block in the same cycle, which lets
  // a waiting producer stream words back to back.
  assign in_ready  = !rst && (!emitting || (out_valid && out_last && out_ready));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    lz_d       = lz_q;
    err_flag_d = err_flag_q | (out_valid & out_ready & out_err);

    if (accept) begin
      state_d = EMIT;
      shreg_d = in_bcd;
      cnt_d   = CNT_W'(DIGITS - 1);
      lz_d    = (SUPPRESS_LZ != 0);
    end else if (emitting) begin
      if (skipping) begin
        shreg_d = shreg_q << DIGIT_W;
        cnt_d   = cnt_q - CNT_W'(1);
      end else begin
        // A visible digit ends the leading-zero run for the rest of the word.
        lz_d = 1'b0;
        if (out_ready) begin
          if (cnt_q != '0) begin
            shreg_d = shreg_q << DIGIT_W;
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      lz_q       <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      lz_q       <= lz_d;
      err_flag_q <= err_flag_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_decimal_decoder_seq.sv
// Self-checking bench: two decoder instances (plain and leading-zero
// suppressing) against a digit-list reference model.
module tb_bcd_to_decimal_decoder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_bcd = '0;

  logic        in_valid_a, in_valid_b, out_ready_a, out_ready_b;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [9:0]  out_dec_a, out_dec_b;
  logic        out_last_a, out_last_b, out_err_a, out_err_b;
  logic        err_flag_a, err_flag_b, busy_a, busy_b;

  logic        in_ready, out_valid, out_last, out_err, err_flag, busy;
  logic [9:0]  out_dec;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          exp_q[$];
  int          exp_skip;
  bit          err_model[2];

  always #5 clk = ~clk;

  assign in_valid_a  = in_valid  & ~sel;
  assign in_valid_b  = in_valid  &  sel;
  assign out_ready_a = out_ready & ~sel;
  assign out_ready_b = out_ready &  sel;

  assign in_ready  = sel ? in_ready_b  : in_ready_a;
  assign out_valid = sel ? out_valid_b : out_valid_a;
  assign out_dec   = sel ? out_dec_b   : out_dec_a;
  assign out_last  = sel ? out_last_b  : out_last_a;
  assign out_err   = sel ? out_err_b   : out_err_a;
  assign err_flag  = sel ? err_flag_b  : err_flag_a;
  assign busy      = sel ? busy_b      : busy_a;

  bcd_to_decimal_decoder_seq #(.DIGITS(4), .SUPPRESS_LZ(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_bcd(in_bcd), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_dec(out_dec_a), .out_last(out_last_a), .out_err(out_err_a),
    .err_flag(err_flag_a), .busy(busy_a)
  );

  bcd_to_decimal_decoder_seq #(.DIGITS(4), .SUPPRESS_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_bcd(in_bcd), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_dec(out_dec_b), .out_last(out_last_b), .out_err(out_err_b),
    .err_flag(err_flag_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the digits a consumer should see, and how many leading
  // zeros are silently dropped before the first one.
  task automatic build(input logic [15:0] w, input bit lz);
    bit started;
    int d;
    exp_q.delete();
    exp_skip = 0;
    started  = !lz;
    for (int i = 3; i >= 0; i--) begin
      d = int'(w[i*4 +: 4]);
      if (!started && d == 0 && i != 0) exp_skip++;
      else begin
        started = 1'b1;
        exp_q.push_back(d);
      end
    end
  endtask

  function automatic logic [31:0] onehot(input int d);
    return (d <= 9) ? (32'd1 << d) : 32'd0;
  endfunction

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles on digit 2
  task automatic run_word(input logic [15:0] w, input int mode);
    int cyc, skips, idx, stall;
    bit seen_valid;
    build(w, sel);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_bcd = w; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0; skips = 0; idx = 0; stall = 0; seen_valid = 1'b0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      check("err_flag", err_flag, err_model[sel]);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (idx == 1 && stall < 5) begin out_ready = 1'b0; stall++; end
          else out_ready = 1'b1;
        end
      endcase
      if (!seen_valid && !out_valid) skips++;
      else begin
        if (!seen_valid) check("lead_skips", skips, exp_skip);
        seen_valid = 1'b1;
        check("out_valid", out_valid, 1);
        check("out_dec", out_dec, onehot(exp_q[0]));
        check("out_last", out_last, exp_q.size() == 1);
        check("out_err", out_err, exp_q[0] > 9);
        if (out_valid && out_ready) begin
          if (exp_q[0] > 9) err_model[sel] = 1'b1;
          void'(exp_q.pop_front());
          idx++;
        end
      end
    end
    check("word_complete", exp_q.size(), 0);
    @(negedge clk);
    out_ready = 1'b0;
    check("busy_after", busy, 0);
    check("err_flag_after", err_flag, err_model[sel]);
  endtask

  initial begin
    int seq[8];
    logic [15:0] w;
    int nib;
    seq = '{5, 5, 5, 5, 6, 7, 8, 9};
    err_model[0] = 1'b0;
    err_model[1] = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_dec", out_dec, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_flag", err_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);

    // Basic, invalid nibble, backpressure on the plain instance
    sel = 1'b0;
    run_word(16'h1234, 0);
    run_word(16'h12A4, 0);
    run_word(16'h0567, 0);
    run_word(16'h9081, 2);

    // Back-to-back words, eight digits on eight consecutive cycles
    @(negedge clk);
    in_bcd = 16'h5555; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) in_bcd = 16'h6789;
      if (i == 4) in_valid = 1'b0;
      check("b2b_valid", out_valid, 1);
      check("b2b_dec", out_dec, onehot(seq[i]));
      check("b2b_last", out_last, (i == 3) || (i == 7));
      if (i == 3) check("b2b_in_ready", in_ready, 1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", busy, 0);

    // Leading-zero suppression on the second instance
    sel = 1'b1;
    run_word(16'h0070, 0);
    run_word(16'h0000, 0);
    run_word(16'h00B3, 1);

    // Randomized words on both instances with random backpressure
    for (int k = 0; k < 24; k++) begin
      sel = k[0];
      w = '0;
      for (int j = 0; j < 4; j++) begin
        nib = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
        w[j*4 +: 4] = 4'(nib);
      end
      run_word(w, 1);
    end

    // Reset in the middle of a word
    sel = 1'b0;
    @(negedge clk);
    in_bcd = 16'h4321; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("mid_d1", out_dec, onehot(4));
    @(negedge clk);
    check("mid_d2", out_dec, onehot(3));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_err_flag", err_flag, 0);
    err_model[0] = 1'b0;
    err_model[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    #1 check("mid_rel_in_ready", in_ready, 1);
    run_word(16'h0001, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_decimal_decoder_seq.md
Name: bcd_to_decimal_decoder_seq

Overview:
Streaming BCD-to-decimal decoder, the inverse of the team's decimal-to-BCD encoder. It accepts a packed multi-digit BCD word over a valid/ready handshake. It then emits one digit per handshake as a 10-bit one-hot decimal code, most significant digit first, with last and error flags. It sits between the BCD arithmetic/counter blocks and per-digit display or annunciator drivers.

Parameters:
DIGITS, 4, number of BCD nibbles per input word (>=1)
SUPPRESS_LZ, 0, 1 = skip leading zero digits; the least significant digit is always emitted

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_bcd holds a word
in_ready  output  1  block can accept a word this cycle
in_bcd  input  4*DIGITS  packed BCD, digit DIGITS-1 in MS nibble
out_valid  output  1  out_dec/out_last/out_err valid
out_ready  input  1  consumer accepts the current digit
out_dec  output  10  one-hot decimal; bit k set for digit k; 0 on an invalid nibble
out_last  output  1  current digit is the final one of the word
out_err  output  1  current nibble is 1010..1111
err_flag  output  1  sticky: any invalid nibble seen since reset
busy  output  1  word in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE; shift register=0; digit counter=0; lz flag=0.
- Reset output values: out_valid=0, out_dec=0, out_last=0, out_err=0, err_flag=0, busy=0.
- in_ready is forced to 0 while rst=1.
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_bcd into the shift register, set counter=DIGITS-1, set lz=SUPPRESS_LZ, then go to EMIT.
- EMIT:
  - Current nibble = MS nibble of the shift register.
  - out_dec = one-hot(nibble) when nibble<=9, else 0 with out_err=1.
  - out_last = (counter==0).
  - All outputs are combinational from registered state, so first-digit latency is 1 cycle after input acceptance.
- Skipping (lz=1 and nibble==0 and counter!=0):
  - out_valid=0.
  - Each cycle: shift left 4, decrement counter. One cycle per skipped digit.
  - Any nonzero nibble, including an invalid one, clears lz.
- Emitting (otherwise):
  - out_valid=1.
  - On out_ready with counter!=0: shift left 4, decrement counter, clear lz.
  - On out_ready with counter==0: word complete.
- Backpressure: while out_valid&!out_ready, out_dec, out_last and out_err hold stable.
- Back-to-back words: in_ready is also 1 in EMIT when out_valid&out_last&out_ready (combinational path from out_ready).
  - If in_valid is high at that point, the new word is captured and state stays EMIT.
  - Otherwise state returns to IDLE.
  - Sustained throughput is DIGITS cycles per word with no suppression.
- err_flag sets in the cycle after an out_err digit handshakes. It clears only on rst.
- in_valid in EMIT outside the last-digit handshake is ignored; the word must be held by the producer.
- All-zero word with SUPPRESS_LZ=1: exactly one digit is emitted (out_dec=0000000001, out_last=1).
- DIGITS=1: every word is a single digit with out_last=1.
- Reset mid-word: the word is discarded immediately; the digit in flight is not completed.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, DEC_W=10.
  - State enum {IDLE, EMIT}.
  - Function bcd_valid(nibble).
- Sub-module bcd_digit_decoder: combinational 4-bit in to 10-bit one-hot out plus invalid flag. Instantiated once, on the MS nibble. It is the exact counterpart of the existing encoder and is reusable by display drivers.

Test Plan:
- Basic sequence: DIGITS=4, in_bcd=16'h1234, out_ready=1 -> out_dec 0000000010, 0000000100, 0000001000, 0000010000 on 4 consecutive cycles; out_last=1 only on the 4th; first out_valid 1 cycle after acceptance.
- Invalid nibble: in_bcd=16'h12A4 -> 3rd digit out_dec=0, out_err=1, out_last=0; err_flag=1 from the next cycle and remains 1 through subsequent valid words.
- Backpressure: in_bcd=16'h9081, out_ready held low 5 cycles on digit 2 -> out_dec=0000000001 stable all 5 cycles; sequence 9,0,8,1 intact.
- Leading-zero suppression: SUPPRESS_LZ=1, in_bcd=16'h0070 -> two skipped cycles with out_valid=0, then 7 (0010000000), then 0 (0000000001, out_last=1); in_bcd=16'h0000 -> single 0 digit with out_last=1.
- Back-to-back: 16'h5555 and 16'h6789 offered continuously -> 8 digits on 8 consecutive cycles; in_ready=1 on the last-digit handshake cycle.
- Reset mid-word: assert rst asynchronously during digit 2 of 16'h4321 -> out_valid=0, busy=0, in_ready=0 immediately; after release in_ready=1 and the next word 16'h0001 decodes correctly.
